// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
// Holds frame geometry (data bits, oversampling, stop ticks), the divisor
// width, FIFO sizing and the receiver FSM state encoding.
package uart_pkg;

  localparam int unsigned DBIT       = 8;   // data bits per frame
  localparam int unsigned SB_TICK    = 32;  // oversample ticks across both stop bits
  localparam int unsigned OVS        = 16;  // oversample ticks per bit
  localparam int unsigned FIFO_AW    = 2;   // FIFO address width
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
  localparam int unsigned DIV_W      = 10;  // baud divisor width
  localparam int unsigned S_W        = 5;   // tick counter (needs 5 bits for STOP)
  localparam int unsigned N_W        = 3;   // data bit counter

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 16x oversampling UART receiver, 8N2, LSB first.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-low reset
//   rx      - serial line, already synchronized to clk
//   s_tick  - oversample tick (1-cycle pulse)
//   rx_out  - last received byte, held until the next rx_done
//   rx_done - 1-cycle pulse when rx_out has been updated
module uart_rx_core
  import uart_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_out,
  output logic            rx_done
);

  rx_state_e       state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] rx_out_q, rx_out_d;
  logic            rx_done_q, rx_done_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      rx_out_q  <= '0;
      rx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      rx_out_q  <= rx_out_d;
      rx_done_q <= rx_done_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          // Mid start bit: confirm the line is still low, else treat as a glitch
          if (s_q == S_W'(OVS / 2 - 1)) begin
            if (!rx) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_W'(OVS - 1)) begin
            b_d = {rx, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_W'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          // Stop-bit level is deliberately not checked
          if (s_q == S_W'(SB_TICK - 1)) begin
            state_d = IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: deliver the byte at the end of the stop period
  always_comb begin
    rx_done_d = 1'b0;
    rx_out_d  = rx_out_q;
    if (state_q == STOP && s_tick && s_q == S_W'(SB_TICK - 1)) begin
      rx_done_d = 1'b1;
      rx_out_d  = b_q;
    end
  end

  assign rx_out  = rx_out_q;
  assign rx_done = rx_done_q;

endmodule

// File: rtl/receiver_test.sv
// UART receive subsystem: rx synchronizer, programmable baud tick generator,
// 8N2 receiver core and a 4-deep first-word-fall-through FIFO.
// Ports:
//   clk          - system clock
//   rst          - synchronous active-low reset
//   read_en      - pop request, ignored while empty
//   read_data    - FIFO head byte, 0x00 when empty
//   empty        - FIFO empty flag
//   rx           - serial line, idle high, asynchronous to clk
//   input_number - baud divisor: tick period in clk cycles
module receiver_test
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             read_en,
  output logic [DBIT-1:0]  read_data,
  output logic             empty,
  input  logic             rx,
  input  logic [DIV_W-1:0] input_number
);

  localparam int unsigned CNT_W = FIFO_AW + 1;

  // rx synchronizer
  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;

  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
    end
  end

  // Baud tick generator; a smaller divisor below the current count wraps at once
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   cnt_inc;
  logic             s_tick;

  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (DIV_W + 1)'(1);
    cnt_d   = (cnt_inc >= {1'b0, input_number}) ? '0 : cnt_inc[DIV_W-1:0];
    s_tick  = rst && (input_number != '0) && (cnt_q == input_number - DIV_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Receiver core
  logic [DBIT-1:0] rx_out;
  logic            rx_done;

  uart_rx_core receive (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx_sync_q),
    .s_tick  (s_tick),
    .rx_out  (rx_out),
    .rx_done (rx_done)
  );

  // FWFT FIFO
  logic [DBIT-1:0]    mem_q [FIFO_DEPTH];
  logic [DBIT-1:0]    mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr_en, rd_en;

  always_comb begin
    // Writes to a full FIFO are dropped; pops of an empty FIFO are ignored
    wr_en    = rx_done && (count_q != CNT_W'(FIFO_DEPTH));
    rd_en    = read_en && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = rx_out;
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head word presented combinationally
  always_comb begin
    empty     = (count_q == '0);
    read_data = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_receiver_test.sv
// Bench for receiver_test: frames are driven on rx, expected bytes are queued
// as each frame is sent and matched against rx_done events in order.
module tb_receiver_test;
  import uart_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             read_en;
  logic [7:0]       read_data;
  logic             empty;
  logic             rx;
  logic [DIV_W-1:0] input_number;

  always #10 clk = ~clk;

  receiver_test dut (
    .clk          (clk),
    .rst          (rst),
    .read_en      (read_en),
    .read_data    (read_data),
    .empty        (empty),
    .rx           (rx),
    .input_number (input_number)
  );

  int checks = 0;
  int passed = 0;
  int div    = 4;

  logic [7:0] exp_q [$];

  // rx_done monitor: records each delivered byte and any pulse wider than 1 cycle
  logic [7:0] got_mem [64];
  int         got_wr    = 0;
  int         got_rd    = 0;
  int         done_wide = 0;
  logic       done_prev = 1'b0;

  always @(negedge clk) begin
    if (dut.receive.rx_done) begin
      if (got_wr < 64) got_mem[got_wr] = dut.receive.rx_out;
      got_wr = got_wr + 1;
      if (done_prev) done_wide = done_wide + 1;
    end
    done_prev = dut.receive.rx_done;
  end

  task automatic send_frame(input logic [7:0] d);
    int bc;
    bc = int'(OVS) * div;
    @(negedge clk);
    rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bc) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * bc) @(negedge clk);
  endtask

  task automatic scoreboard_drain(input string name);
    logic [7:0] e;
    logic [7:0] g;
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_rd < got_wr) begin
        g = got_mem[got_rd];
        got_rd++;
        if (g !== e) $display("FAIL %s rx_out: got %02h, required %02h", name, g, e);
        else passed++;
      end else begin
        $display("FAIL %s rx_done missing: got no byte, required %02h", name, e);
      end
    end
    checks++;
    if (got_rd != got_wr) begin
      $display("FAIL %s extra rx_done: got %0d extra, required 0", name, got_wr - got_rd);
      got_rd = got_wr;
    end else passed++;
    checks++;
    if (done_wide != 0) begin
      $display("FAIL %s rx_done width: got %0d wide pulses, required 0", name, done_wide);
      done_wide = 0;
    end else passed++;
  endtask

  task automatic test_reset();
    int ticks;
    int cyc;
    bit found;
    rst = 1'b0; rx = 1'b1; read_en = 1'b0; input_number = 10'd325;
    ticks = 0;
    repeat (400) begin
      @(negedge clk);
      if (dut.s_tick) ticks++;
    end
    checks++; if (empty !== 1'b1) $display("FAIL reset empty: got %b, required 1", empty); else passed++;
    checks++; if (read_data !== 8'h00) $display("FAIL reset read_data: got %02h, required 00", read_data); else passed++;
    checks++; if (ticks != 0) $display("FAIL reset s_tick: got %0d ticks, required 0", ticks); else passed++;
    checks++; if (dut.receive.rx_out !== 8'h00) $display("FAIL reset rx_out: got %02h, required 00", dut.receive.rx_out); else passed++;
    rst = 1'b1;
    cyc = 0; found = 0;
    while (!found && cyc < 1000) begin
      @(negedge clk); cyc++;
      if (dut.s_tick) found = 1;
    end
    checks++; if (cyc != 324) $display("FAIL tick first: got %0d cycles, required 324", cyc); else passed++;
    cyc = 0; found = 0;
    while (!found && cyc < 1000) begin
      @(negedge clk); cyc++;
      if (dut.s_tick) found = 1;
    end
    checks++; if (cyc != 325) $display("FAIL tick period: got %0d cycles, required 325", cyc); else passed++;
    input_number = 10'(div);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_frame();
    exp_q.push_back(8'h0F);
    send_frame(8'h0F);
    scoreboard_drain("single");
    checks++; if (empty !== 1'b0) $display("FAIL single empty: got %b, required 0", empty); else passed++;
    checks++; if (read_data !== 8'h0F) $display("FAIL single read_data: got %02h, required 0F", read_data); else passed++;
  endtask

  task automatic test_pop();
    @(negedge clk); read_en = 1'b1;
    @(negedge clk); read_en = 1'b0;
    checks++; if (empty !== 1'b1) $display("FAIL pop empty: got %b, required 1", empty); else passed++;
    checks++; if (read_data !== 8'h00) $display("FAIL pop read_data: got %02h, required 00", read_data); else passed++;
    read_en = 1'b1;
    repeat (5) @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1 || read_data !== 8'h00)
      $display("FAIL pop_empty: got empty=%b data=%02h, required empty=1 data=00", empty, read_data);
    else passed++;
  endtask

  task automatic test_glitch();
    @(negedge clk); rx = 1'b0;
    repeat (3 * div) @(negedge clk);
    rx = 1'b1;
    repeat (3 * int'(OVS) * div) @(negedge clk);
    scoreboard_drain("glitch");
    checks++; if (dut.receive.state_q !== IDLE) $display("FAIL glitch state: got %0d, required %0d", dut.receive.state_q, IDLE); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL glitch empty: got %b, required 1", empty); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i));
    end
    scoreboard_drain("b2b");
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (empty !== 1'b0 || read_data !== 8'(i))
        $display("FAIL b2b pop%0d: got empty=%b data=%02h, required empty=0 data=%02h", i, empty, read_data, 8'(i));
      else passed++;
      read_en = 1'b1;
      @(negedge clk); read_en = 1'b0;
    end
    checks++; if (empty !== 1'b1) $display("FAIL b2b final empty: got %b, required 1", empty); else passed++;
  endtask

  task automatic test_reset_mid();
    int bc;
    bc = int'(OVS) * div;
    @(negedge clk); rx = 1'b0;
    repeat (bc) @(negedge clk);
    rx = 1'b1; repeat (bc) @(negedge clk);
    rx = 1'b0; repeat (bc) @(negedge clk);
    rx = 1'b1; repeat (bc / 2) @(negedge clk);
    checks++; if (dut.receive.state_q !== DATA) $display("FAIL mid state: got %0d, required %0d", dut.receive.state_q, DATA); else passed++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dut.receive.state_q !== IDLE || dut.receive.rx_out !== 8'h00)
      $display("FAIL mid reset: got state=%0d rx_out=%02h, required state=0 rx_out=00", dut.receive.state_q, dut.receive.rx_out);
    else passed++;
    repeat (2 * bc) @(negedge clk);
    checks++; if (empty !== 1'b1) $display("FAIL mid empty: got %b, required 1", empty); else passed++;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5);
    scoreboard_drain("after_reset");
    checks++; if (read_data !== 8'hA5) $display("FAIL after_reset read_data: got %02h, required A5", read_data); else passed++;
    @(negedge clk); read_en = 1'b1;
    @(negedge clk); read_en = 1'b0;
  endtask

  task automatic test_stream();
    int low_cycles;
    logic [7:0] seen;
    low_cycles = 0; seen = 8'h00;
    read_en = 1'b1;
    exp_q.push_back(8'h3C);
    fork
      send_frame(8'h3C);
      begin
        repeat (12 * int'(OVS) * div) begin
          @(negedge clk);
          if (!empty) begin
            low_cycles++;
            seen = read_data;
          end
        end
      end
    join
    read_en = 1'b0;
    scoreboard_drain("stream");
    checks++; if (low_cycles != 1) $display("FAIL stream empty low: got %0d cycles, required 1", low_cycles); else passed++;
    checks++; if (seen !== 8'h3C) $display("FAIL stream data: got %02h, required 3C", seen); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL stream final empty: got %b, required 1", empty); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_pop();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_stream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
